// File: rtl/pong_game_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pong_pkg                                                  |
// | Description : Shared Pong types: game state encoding, screen size and   |
// |               object colours.                                           |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_SCORED    = 3'd3,
      ST_GAME_OVER = 3'd4
   } game_state_e;

   localparam int HRES = 1280;
   localparam int VRES = 720;

   // 4:4:4 RGB object colours
   localparam logic [11:0] c_colour_bg     = 12'h000;
   localparam logic [11:0] c_colour_paddle = 12'hFFF;
   localparam logic [11:0] c_colour_ball   = 12'hFF0;

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pong_game_ctrl_if                                         |
// | Description : Game-control signal bundle between the frame/collision    |
// |               logic (master) and the game sequencer (slave).            |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
interface pong_game_ctrl_if #(
   parameter int SCORE_W = 4
);
   logic               fsync;
   logic               start;
   logic               miss_top;
   logic               miss_bot;
   logic               run;
   logic               obj_rst;
   logic [SCORE_W-1:0] score_top;
   logic [SCORE_W-1:0] score_bot;
   logic [2:0]         state;
   logic               winner;

   modport master (
      output fsync, start, miss_top, miss_bot,
      input  run, obj_rst, score_top, score_bot, state, winner
   );

   modport slave (
      input  fsync, start, miss_top, miss_bot,
      output run, obj_rst, score_top, score_bot, state, winner
   );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl_btn_sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : btn_sync_edge                                             |
// | Description : Two-flop synchroniser for an asynchronous push-button     |
// |               followed by a registered rising-edge detector.            |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
module btn_sync_edge (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic btn,
   output logic      btn_p
);
   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_pulse;

   // Synchronise the button, then emit one pulse per 0->1 transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_meta  <= btn;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_pulse <= r_sync & ~r_prev;
      end
   end

   assign btn_p = r_pulse;
endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pong_game_ctrl                                            |
// | Description : Pong game sequencer: idle, serve, play, score-hold and    |
// |               game-over, frame-timed by fsync; keeps both scores.       |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE         = 5,
   parameter int SCORE_W           = 4,
   parameter int SERVE_FRAMES      = 60,
   parameter int SCORE_HOLD_FRAMES = 120,
   parameter int FRAME_CNT_W       = 8
) (
   input  wire logic        pixel_clk,
   input  wire logic        rst_n,
   pong_game_ctrl_if.slave  bus
);
   localparam logic [SCORE_W-1:0]     c_win_score  = SCORE_W'(WIN_SCORE);
   localparam logic [FRAME_CNT_W-1:0] c_serve_last = FRAME_CNT_W'(SERVE_FRAMES - 1);
   localparam logic [FRAME_CNT_W-1:0] c_hold_last  = FRAME_CNT_W'(SCORE_HOLD_FRAMES - 1);

   game_state_e            r_state;
   logic                   r_run;
   logic                   r_obj_rst;
   logic                   r_winner;
   logic                   r_miss_top;
   logic                   r_miss_bot;
   logic [SCORE_W-1:0]     r_score_top;
   logic [SCORE_W-1:0]     r_score_bot;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;

   logic                   w_start_p;
   logic                   w_miss_top;
   logic                   w_miss_bot;
   logic [SCORE_W-1:0]     w_top_inc;
   logic [SCORE_W-1:0]     w_bot_inc;

   btn_sync_edge u_start_sync (
      .clk   (pixel_clk),
      .rst_n (rst_n),
      .btn   (bus.start),
      .btn_p (w_start_p)
   );

   // A miss arriving on the fsync cycle itself still belongs to that frame
   assign w_miss_top = r_miss_top | bus.miss_top;
   assign w_miss_bot = r_miss_bot | bus.miss_bot;
   assign w_top_inc  = r_score_top + SCORE_W'(1);
   assign w_bot_inc  = r_score_bot + SCORE_W'(1);

   // Game FSM with frame counter, miss latches, scores and registered outputs
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_run       <= 1'b0;
         r_obj_rst   <= 1'b0;
         r_winner    <= 1'b0;
         r_miss_top  <= 1'b0;
         r_miss_bot  <= 1'b0;
         r_score_top <= '0;
         r_score_bot <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_obj_rst <= 1'b0;
         case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
               // start beats a simultaneous fsync: that frame is not counted
               if (w_start_p) begin
                  r_state     <= ST_SERVE;
                  r_obj_rst   <= 1'b1;
                  r_score_top <= '0;
                  r_score_bot <= '0;
                  r_winner    <= 1'b0;
                  r_frame_cnt <= '0;
               end
            end
            ST_SERVE: begin
               if (bus.fsync) begin
                  if (r_frame_cnt == c_serve_last) begin
                     r_state     <= ST_PLAY;
                     r_run       <= 1'b1;
                     r_frame_cnt <= '0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
                  end
               end
            end
            ST_PLAY: begin
               if (bus.fsync) begin
                  r_miss_top  <= 1'b0;
                  r_miss_bot  <= 1'b0;
                  if (w_miss_top || w_miss_bot) begin
                     r_run       <= 1'b0;
                     r_frame_cnt <= '0;
                     r_state     <= ST_SCORED;
                  end
                  // Exactly one side missed: the other side scores
                  if (w_miss_top && !w_miss_bot) begin
                     r_score_bot <= w_bot_inc;
                     if (w_bot_inc == c_win_score) begin
                        r_state  <= ST_GAME_OVER;
                        r_winner <= 1'b1;
                     end
                  end else if (w_miss_bot && !w_miss_top) begin
                     r_score_top <= w_top_inc;
                     if (w_top_inc == c_win_score) begin
                        r_state  <= ST_GAME_OVER;
                        r_winner <= 1'b0;
                     end
                  end
               end else begin
                  r_miss_top <= w_miss_top;
                  r_miss_bot <= w_miss_bot;
               end
            end
            ST_SCORED: begin
               if (bus.fsync) begin
                  if (r_frame_cnt == c_hold_last) begin
                     r_state     <= ST_SERVE;
                     r_obj_rst   <= 1'b1;
                     r_frame_cnt <= '0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_run   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.run       = r_run;
   assign bus.obj_rst   = r_obj_rst;
   assign bus.score_top = r_score_top;
   assign bus.score_bot = r_score_bot;
   assign bus.state     = r_state;
   assign bus.winner    = r_winner;
endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_pong_game_ctrl                                         |
// | Description : Scoreboard bench for pong_game_ctrl: every change of the  |
// |               observable outputs is matched against an expected queue.  |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;
   localparam int SW = 4;

   logic pixel_clk = 1'b0;
   logic rst_n     = 1'b1;
   int   errors    = 0;
   int   checks    = 0;

   typedef struct packed {
      logic [2:0]    st;
      logic          run;
      logic          orst;
      logic [SW-1:0] top;
      logic [SW-1:0] bot;
      logic          win;
   } obs_t;

   obs_t exp_q[$];

   pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

   pong_game_ctrl #(
      .WIN_SCORE         (2),
      .SCORE_W           (SW),
      .SERVE_FRAMES      (2),
      .SCORE_HOLD_FRAMES (3),
      .FRAME_CNT_W       (8)
   ) dut (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   always #5 pixel_clk = ~pixel_clk;

   function automatic obs_t mk(int st, bit run, bit orst, int top, int bot, bit win);
      obs_t o;
      o.st   = 3'(st);
      o.run  = run;
      o.orst = orst;
      o.top  = SW'(top);
      o.bot  = SW'(bot);
      o.win  = win;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.st   = bus.state;
      o.run  = bus.run;
      o.orst = bus.obj_rst;
      o.top  = bus.score_top;
      o.bot  = bus.score_bot;
      o.win  = bus.winner;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic wait_state(input int st, input int max_cyc, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge pixel_clk);
         if (bus.state == 3'(st)) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: state=%0d required %0d within %0d cycles", nm, bus.state, st, max_cyc);
      end
   endtask

   // Single-cycle miss pulse a few cycles into the next frame
   task automatic mid_frame_miss(input bit top);
      @(posedge bus.fsync);
      repeat (4) @(posedge pixel_clk);
      #1;
      if (top) bus.miss_top = 1'b1; else bus.miss_bot = 1'b1;
      @(posedge pixel_clk);
      #1;
      bus.miss_top = 1'b0;
      bus.miss_bot = 1'b0;
   endtask

   task automatic push_serve(input int top, input int bot);
      exp_q.push_back(mk(1, 0, 1, top, bot, 0));
      exp_q.push_back(mk(1, 0, 0, top, bot, 0));
   endtask

   // Frame pulse: one cycle high every 10 cycles
   initial begin
      bus.fsync = 1'b0;
      forever begin
         repeat (9) @(posedge pixel_clk);
         #1 bus.fsync = 1'b1;
         @(posedge pixel_clk);
         #1 bus.fsync = 1'b0;
      end
   end

   // Monitor: each change of the output tuple must be the next expected one
   initial begin
      obs_t last;
      obs_t cur;
      obs_t e;
      last = mk(0, 0, 0, 0, 0, 0);
      forever begin
         @(negedge pixel_clk);
         cur = sample();
         if (cur !== last) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: got %h required %h (no change)", cur, last);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  errors++;
                  $display("FAIL scoreboard: got %h required %h", cur, e);
               end
            end
            last = cur;
         end
      end
   end

   // Directed game sequence
   initial begin
      bus.start    = 1'b0;
      bus.miss_top = 1'b0;
      bus.miss_bot = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge pixel_clk);
      #1 rst_n = 1'b1;
      @(negedge pixel_clk);
      chk("reset_state", 32'(sample()), 32'(mk(0, 0, 0, 0, 0, 0)));

      // 1: idle for five frames, then start
      repeat (50) @(posedge pixel_clk);
      chk("idle_hold", 32'(bus.state), 0);
      push_serve(0, 0);
      #1 bus.start = 1'b1;
      repeat (3) @(posedge pixel_clk);
      @(negedge pixel_clk);
      chk("start_latency_before", 32'(bus.state), 0);
      @(negedge pixel_clk);
      chk("start_latency_state", 32'(bus.state), 1);
      chk("start_obj_rst", 32'(bus.obj_rst), 1);
      @(negedge pixel_clk);
      chk("obj_rst_one_cycle", 32'(bus.obj_rst), 0);
      // miss during SERVE is ignored
      bus.miss_top = 1'b1;
      @(negedge pixel_clk);
      bus.miss_top = 1'b0;
      exp_q.push_back(mk(2, 1, 0, 0, 0, 0));
      wait_state(2, 60, "serve_to_play");

      // 2: start toggled in PLAY is ignored, then top misses
      bus.start = 1'b0;
      repeat (3) @(posedge pixel_clk);
      #1 bus.start = 1'b1;
      repeat (6) @(posedge pixel_clk);
      exp_q.push_back(mk(3, 0, 0, 0, 1, 0));
      mid_frame_miss(1'b1);
      wait_state(3, 30, "play_to_scored");
      chk("scored_run", 32'(bus.run), 0);
      push_serve(0, 1);
      @(negedge pixel_clk);
      bus.miss_bot = 1'b1;
      @(negedge pixel_clk);
      bus.miss_bot = 1'b0;
      wait_state(1, 60, "scored_to_serve");
      exp_q.push_back(mk(2, 1, 0, 0, 1, 0));
      wait_state(2, 60, "serve_to_play_2");

      // 3: both miss in one frame -> draw
      exp_q.push_back(mk(3, 0, 0, 0, 1, 0));
      @(posedge bus.fsync);
      repeat (2) @(posedge pixel_clk);
      #1 bus.miss_top = 1'b1;
      @(posedge pixel_clk);
      #1 bus.miss_top = 1'b0;
      repeat (2) @(posedge pixel_clk);
      #1 bus.miss_bot = 1'b1;
      @(posedge pixel_clk);
      #1 bus.miss_bot = 1'b0;
      wait_state(3, 30, "draw_to_scored");
      chk("draw_scores", 32'({bus.score_top, bus.score_bot}), 32'h01);
      push_serve(0, 1);
      wait_state(1, 60, "draw_to_serve");
      exp_q.push_back(mk(2, 1, 0, 0, 1, 0));
      wait_state(2, 60, "draw_to_play");

      // miss coincident with fsync counts in that frame
      exp_q.push_back(mk(3, 0, 0, 1, 1, 0));
      @(posedge bus.fsync);
      bus.miss_bot = 1'b1;
      @(posedge pixel_clk);
      #1 bus.miss_bot = 1'b0;
      @(negedge pixel_clk);
      chk("coincident_miss", 32'(bus.score_top), 1);
      push_serve(1, 1);
      wait_state(1, 60, "coinc_to_serve");
      exp_q.push_back(mk(2, 1, 0, 1, 1, 0));
      wait_state(2, 60, "coinc_to_play");

      // 4: bottom reaches WIN_SCORE
      exp_q.push_back(mk(4, 0, 0, 1, 2, 1));
      mid_frame_miss(1'b1);
      wait_state(4, 30, "game_over");
      @(negedge pixel_clk);
      bus.miss_top = 1'b1;
      bus.miss_bot = 1'b1;
      repeat (12) @(negedge pixel_clk);
      bus.miss_top = 1'b0;
      bus.miss_bot = 1'b0;
      repeat (20) @(negedge pixel_clk);
      chk("game_over_hold", 32'(sample()), 32'(mk(4, 0, 0, 1, 2, 1)));
      push_serve(0, 0);
      bus.start = 1'b0;
      repeat (4) @(negedge pixel_clk);
      bus.start = 1'b1;
      wait_state(1, 20, "restart_serve");
      exp_q.push_back(mk(2, 1, 0, 0, 0, 0));
      wait_state(2, 60, "restart_play");

      // top scores once so the reset hits a non-zero score
      exp_q.push_back(mk(3, 0, 0, 1, 0, 0));
      mid_frame_miss(1'b0);
      wait_state(3, 30, "top_scores");
      push_serve(1, 0);
      wait_state(1, 60, "top_to_serve");
      exp_q.push_back(mk(2, 1, 0, 1, 0, 0));
      wait_state(2, 60, "top_to_play");

      // 6: asynchronous reset mid-PLAY
      bus.start = 1'b0;
      repeat (3) @(negedge pixel_clk);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      @(posedge pixel_clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset", 32'(sample()), 32'(mk(0, 0, 0, 0, 0, 0)));
      repeat (2) @(posedge pixel_clk);
      #1 rst_n = 1'b1;
      repeat (15) @(negedge pixel_clk);
      chk("after_reset_idle", 32'(bus.state), 0);

      // start_p coincident with fsync in IDLE: that frame is not counted
      push_serve(0, 0);
      @(posedge bus.fsync);
      repeat (7) @(posedge pixel_clk);
      #1 bus.start = 1'b1;
      wait_state(1, 10, "coinc_start_serve");
      repeat (15) @(negedge pixel_clk);
      chk("coinc_start_not_counted", 32'(bus.state), 1);
      exp_q.push_back(mk(2, 1, 0, 0, 0, 0));
      wait_state(2, 30, "coinc_start_play");

      repeat (3) @(negedge pixel_clk);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
